// File: rtl/spram_hs.sv
// spram_hs: single-port synchronous RAM with a valid/ready request port,
// byte-lane write enables, selectable read-during-write response, optional
// output register and a post-reset clear sequencer that zeroes the array.
module spram_hs #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 8,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    init_done
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {S_RESET, S_CLEAR, S_RUN} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    clearing;
    logic                    accept;
    logic                    in_range;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   new_word;
    logic                    rsp_fire;
    logic [DATA_WIDTH-1:0]   rsp_data;

    logic                    vld_p0;
    logic [DATA_WIDTH-1:0]   rdata_p0;
    logic                    err_p0;

    // Replace the enabled byte lanes of the stored word with the write data.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [LANES-1:0]      be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    // A clear write happens on every rst-low edge until the last word is zeroed.
    assign clearing = (CLEAR_ON_RESET != 0) && (state != S_RUN) && !rst;
    // Requests presented while rst is sampled high are dropped entirely.
    assign accept   = req_valid && req_ready && !rst;
    assign in_range = {1'b0, req_addr} < DEPTH_W;
    assign old_word = in_range ? mem[req_addr] : '0;
    assign new_word = merge_lanes(old_word, req_wdata, req_be);
    assign rsp_fire = accept && (!req_we || (RDW_MODE != 0));
    assign rsp_data = !in_range ? '0 :
                      (req_we && (RDW_MODE == 2)) ? new_word : old_word;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_RESET;
        else     state <= state_next;
    end

    // Next-state: leave clearing on the edge that zeroes the last word.
    always_comb begin
        state_next = state;
        case (state)
            S_RESET: begin
                if ((CLEAR_ON_RESET == 0) || (clr_addr == LAST_ADDR)) state_next = S_RUN;
                else                                                  state_next = S_CLEAR;
            end
            S_CLEAR: if (clr_addr == LAST_ADDR) state_next = S_RUN;
            S_RUN:   state_next = S_RUN;
            default: state_next = S_RESET;
        endcase
    end

    // Outputs: requests are only taken once the array is initialised.
    always_comb begin
        req_ready = (state == S_RUN);
        init_done = (state == S_RUN);
    end

    // Clear counter walks 0..DEPTH-1 and restarts from 0 on any reset.
    always_ff @(posedge clk) begin
        if (rst)                         clr_addr <= '0;
        else if (clearing)               clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + 1'b1;
    end

    // Storage array: clear writes take priority, out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (clearing)                             mem[clr_addr] <= '0;
        else if (accept && req_we && in_range)    mem[req_addr] <= new_word;
    end

    // Stage p0: capture the response; data holds while no response is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            rdata_p0 <= '0;
            err_p0   <= 1'b0;
        end else begin
            vld_p0 <= rsp_fire;
            if (rsp_fire) begin
                rdata_p0 <= rsp_data;
                err_p0   <= !in_range;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  vld_p1;
        logic [DATA_WIDTH-1:0] rdata_p1;
        logic                  err_p1;

        // Stage p1: optional extra output register, same hold behaviour.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p1   <= 1'b0;
                rdata_p1 <= '0;
                err_p1   <= 1'b0;
            end else begin
                vld_p1 <= vld_p0;
                if (vld_p0) begin
                    rdata_p1 <= rdata_p0;
                    err_p1   <= err_p0;
                end
            end
        end

        assign rsp_valid = vld_p1;
        assign rsp_rdata = rdata_p1;
        assign rsp_err   = err_p1;
    end else begin : g_no_out_reg
        assign rsp_valid = vld_p0;
        assign rsp_rdata = rdata_p0;
        assign rsp_err   = err_p0;
    end

endmodule

// File: tb/tb_spram_hs.sv
// Bench for spram_hs: three configurations share one request stream and are
// compared every cycle against a behavioural model, plus directed literal checks.
module tb_spram_hs;
    localparam int N = 3;

    // Per-instance configuration (must match the instantiations below).
    function automatic int dep(input int i);  return (i == 0) ? 8 : 6; endfunction
    function automatic int rdw(input int i);  return i;                endfunction
    function automatic bit oreg(input int i); return (i == 1);         endfunction
    function automatic bit clr(input int i);  return (i != 2);         endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;

    logic [N-1:0] rdy, vld, err, done;
    logic [15:0]  rdata [N];

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    spram_hs #(.DATA_WIDTH(16), .DEPTH(8), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld[0]),
        .rsp_rdata(rdata[0]), .rsp_err(err[0]), .init_done(done[0]));
    spram_hs #(.DATA_WIDTH(16), .DEPTH(6), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld[1]),
        .rsp_rdata(rdata[1]), .rsp_err(err[1]), .init_done(done[1]));
    spram_hs #(.DATA_WIDTH(16), .DEPTH(6), .RDW_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(0)) u2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld[2]),
        .rsp_rdata(rdata[2]), .rsp_err(err[2]), .init_done(done[2]));

    // Behavioural model state.
    logic [15:0] mem_m  [N][8];
    bit          known  [N][8];
    int          lowcnt [N];
    bit          rdy_m  [N];
    bit          hold_v [N];
    logic [15:0] hold_d [N];
    bit          hold_e [N];
    bit          hold_k [N];
    bit          ev [N];
    logic [15:0] ed [N];
    bit          ee [N];
    bit          ek [N];

    // Model: at each edge decide acceptance, update the array, schedule the response.
    always @(posedge clk) begin
        bit          inr, nv, ne, nk, v, e, k, oldk;
        logic [15:0] old, upd, nd, d;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                lowcnt[i] = 0; rdy_m[i] = 1'b0; hold_v[i] = 1'b0;
                ev[i] = 1'b0; ed[i] = '0; ee[i] = 1'b0; ek[i] = 1'b1;
                if (clr(i)) begin
                    for (int a = 0; a < 8; a++) begin
                        mem_m[i][a] = '0; known[i][a] = 1'b1;
                    end
                end
            end else begin
                nv = 1'b0; ne = 1'b0; nk = 1'b1; nd = '0;
                if (rdy_m[i] && req_valid) begin
                    inr  = int'(req_addr) < dep(i);
                    old  = inr ? mem_m[i][req_addr] : 16'h0000;
                    oldk = inr ? known[i][req_addr] : 1'b1;
                    upd  = {req_be[1] ? req_wdata[15:8] : old[15:8],
                            req_be[0] ? req_wdata[7:0]  : old[7:0]};
                    ne = !inr;
                    if (req_we) begin
                        nv = (rdw(i) != 0);
                        if (!inr)             begin nd = '0;  nk = 1'b1; end
                        else if (rdw(i) == 1) begin nd = old; nk = oldk; end
                        else begin nd = upd; nk = oldk || (req_be == 2'b11); end
                        if (inr) begin
                            mem_m[i][req_addr] = upd;
                            known[i][req_addr] = oldk || (req_be == 2'b11);
                        end
                    end else begin
                        nv = 1'b1; nd = old; nk = oldk;
                    end
                end
                if (oreg(i)) begin
                    v = hold_v[i]; d = hold_d[i]; e = hold_e[i]; k = hold_k[i];
                    hold_v[i] = nv; hold_d[i] = nd; hold_e[i] = ne; hold_k[i] = nk;
                end else begin
                    v = nv; d = nd; e = ne; k = nk;
                end
                ev[i] = v;
                if (v) begin ed[i] = d; ee[i] = e; ek[i] = k; end
                lowcnt[i]++;
                rdy_m[i] = lowcnt[i] >= (clr(i) ? dep(i) : 1);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one request (or idle) and advance to the next falling edge.
    task automatic put(input bit v, input bit we, input logic [2:0] a,
                       input logic [15:0] d, input logic [1:0] be);
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        @(negedge clk);
    endtask

    // Called on the falling edge where rst has just been dropped.
    task automatic clear_timing();
        rst = 1'b0;
        check("rdy0_pre", 16'(rdy[0]), 16'h0);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("clr_rdy0_k%0d", k),  16'(rdy[0]),  16'(k >= 7));
            check($sformatf("clr_done0_k%0d", k), 16'(done[0]), 16'(k >= 7));
            check($sformatf("clr_rdy1_k%0d", k),  16'(rdy[1]),  16'(k >= 5));
            check($sformatf("clr_rdy2_k%0d", k),  16'(rdy[2]),  16'h1);
        end
    endtask

    logic [15:0] st [8];

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (cmp_on) begin
                    for (int i = 0; i < N; i++) begin
                        check($sformatf("ready%0d", i), 16'(rdy[i]),  16'(rdy_m[i]));
                        check($sformatf("done%0d", i),  16'(done[i]), 16'(rdy_m[i]));
                        check($sformatf("valid%0d", i), 16'(vld[i]),  16'(ev[i]));
                        if (ev[i]) check($sformatf("err%0d", i), 16'(err[i]), 16'(ee[i]));
                        if (ek[i]) check($sformatf("rdata%0d", i), rdata[i], ed[i]);
                    end
                end
            end
        join_none

        @(posedge clk);
        cmp_on = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("rst_ready", 16'(rdy[i]), 16'h0);
            check("rst_valid", 16'(vld[i]), 16'h0);
            check("rst_rdata", rdata[i], 16'h0000);
            check("rst_err",   16'(err[i]), 16'h0);
            check("rst_done",  16'(done[i]), 16'h0);
        end
        @(negedge clk);
        clear_timing();

        // Fill every word so the non-clearing instance has defined contents.
        for (int a = 0; a < 8; a++) put(1'b1, 1'b1, 3'(a), 16'h1000 + 16'(a), 2'b11);

        // Byte enables.
        put(1'b1, 1'b1, 3'd3, 16'hABCD, 2'b11);
        put(1'b1, 1'b1, 3'd3, 16'h1234, 2'b01);
        check("be_wf_u2", rdata[2], 16'hAB34);
        check("be_rf_u1", rdata[1], 16'h1003);
        put(1'b1, 1'b0, 3'd3, 16'h0, 2'b00);
        check("be_rd_v0", 16'(vld[0]), 16'h1);
        check("be_rd_u0", rdata[0], 16'hAB34);
        put(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
        check("be_rd_v1", 16'(vld[1]), 16'h1);
        check("be_rd_u1", rdata[1], 16'hAB34);

        // Read-during-write at address 5.
        put(1'b1, 1'b1, 3'd5, 16'h00FF, 2'b11);
        check("rdw0_novld_a", 16'(vld[0]), 16'h0);
        put(1'b1, 1'b1, 3'd5, 16'h1100, 2'b11);
        check("rdw0_novld_b", 16'(vld[0]), 16'h0);
        check("rdw2_v", 16'(vld[2]), 16'h1);
        check("rdw2_d", rdata[2], 16'h1100);
        put(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
        check("rdw1_v", 16'(vld[1]), 16'h1);
        check("rdw1_d", rdata[1], 16'h00FF);

        // Out-of-range accesses on the six-word instances.
        put(1'b1, 1'b1, 3'd6, 16'hBEEF, 2'b11);
        check("oor_w_err", 16'(err[2]), 16'h1);
        check("oor_w_d",   rdata[2], 16'h0000);
        put(1'b1, 1'b0, 3'd6, 16'h0, 2'b00);
        check("oor_r_err", 16'(err[2]), 16'h1);
        check("oor_r_d",   rdata[2], 16'h0000);
        put(1'b1, 1'b0, 3'd5, 16'h0, 2'b00);
        check("oor_a5_err", 16'(err[2]), 16'h0);
        check("oor_a5_d",   rdata[2], 16'h1100);
        check("oor_u1_err", 16'(err[1]), 16'h1);
        check("oor_u1_d",   rdata[1], 16'h0000);
        put(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
        check("oor_u1_a5", rdata[1], 16'h1100);

        // Streaming reads on the eight-word instance.
        st[0] = 16'h1000; st[1] = 16'h1001; st[2] = 16'h1002; st[3] = 16'hAB34;
        st[4] = 16'h1004; st[5] = 16'h1100; st[6] = 16'hBEEF; st[7] = 16'h1007;
        for (int a = 0; a < 8; a++) begin
            put(1'b1, 1'b0, 3'(a), 16'h0, 2'b00);
            check($sformatf("stream_v%0d", a), 16'(vld[0]), 16'h1);
            check($sformatf("stream_d%0d", a), rdata[0], st[a]);
        end
        put(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
        check("stream_end", 16'(vld[0]), 16'h0);
        check("stream_hold", rdata[0], 16'h1007);

        // Reset with reads in flight and a read presented during reset.
        put(1'b1, 1'b0, 3'd3, 16'h0, 2'b00);
        rst = 1'b1;
        put(1'b1, 1'b0, 3'd4, 16'h0, 2'b00);
        check("rstf_v0", 16'(vld[0]), 16'h0);
        check("rstf_v1", 16'(vld[1]), 16'h0);
        check("rstf_v2", 16'(vld[2]), 16'h0);
        rst = 1'b0;
        put(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
        check("rstf_v1b", 16'(vld[1]), 16'h0);
        check("rstf_v2b", 16'(vld[2]), 16'h0);
        @(negedge clk);
        @(negedge clk);
        check("midclr_rdy0", 16'(rdy[0]), 16'h0);
        rst = 1'b1;
        @(negedge clk);
        clear_timing();

        // Contents of the non-clearing instance survived the resets.
        put(1'b1, 1'b0, 3'd3, 16'h0, 2'b00);
        check("survive_u2", rdata[2], 16'hAB34);
        check("cleared_u0", rdata[0], 16'h0000);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 99) < 2);
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 3'($urandom_range(0, 7));
            req_wdata = 16'($urandom);
            req_be    = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        rst = 1'b0;
        req_valid = 1'b0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spram_hs.md
# spram_hs

Parametrised single-port synchronous RAM with a valid/ready request interface, per-lane byte enables, a selectable read-during-write mode, an optional output register and a hardware clear sequencer that zeroes the array after reset. It replaces tri-state shared data buses with separate write and read buses, and it is the standard storage primitive behind register files and small buffers in the design. One access is performed per cycle.

## Interface
- DATA_WIDTH, 16: word width in bits; must be a multiple of 8.
- DEPTH, 8: number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH): address width in bits.
- RDW_MODE, 0: response to a write. 0 gives no response; 1 returns the old word (read-first); 2 returns the new word (write-first).
- OUT_REG, 0: 1 adds one output pipeline stage.
- CLEAR_ON_RESET, 1: 1 zeroes every word after reset before accepting requests.
- clk  in  1  clock; all activity on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 is a write, 0 is a read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  byte-lane enables for writes; ignored on reads.
- rsp_valid  out  1  rsp_rdata/rsp_err valid; single-cycle pulse per response.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_err  out  1  the request addressed a word ≥ DEPTH.
- init_done  out  1  the clear sequence is finished.

## Operation
- A request is accepted on a rising edge where req_valid && req_ready.
- FSM states:
  - RESET: rst high.
  - CLEAR: a counter clr_addr writes zero to addresses 0 to DEPTH-1, one per cycle. req_ready=0.
  - RUN: req_ready=1 every cycle.
- Transitions:
  - RESET goes to CLEAR when CLEAR_ON_RESET=1, otherwise directly to RUN.
  - CLEAR goes to RUN on the cycle that writes address DEPTH-1.
- Read: the response returns mem[req_addr].
- Write:
  - Lane i (bits 8i+7:8i) is updated only if req_be[i]=1.
  - req_be=0 is a legal no-op write. It still produces a response when RDW_MODE≠0.
- RDW_MODE 1 returns the pre-write word. RDW_MODE 2 returns the post-write merged word, so disabled lanes show their old bytes.
- Out-of-range address (req_addr ≥ DEPTH):
  - Memory is unmodified.
  - A response is issued wherever one would be for an in-range access, with rsp_rdata=0 and rsp_err=1.
- rsp_rdata holds its last value when rsp_valid=0. It does not return to zero.
- No response backpressure: the consumer must take rsp_valid when it is asserted.
- Reset mid-operation:
  - rst during CLEAR restarts the counter at 0.
  - rst discards any in-flight responses; no rsp_valid is produced for requests accepted in the cycle rst is sampled high.
  - With CLEAR_ON_RESET=0, memory contents survive reset.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, clr_addr=0.
- Clear duration, with rst deasserted before edge E0:
  - Zero-writes occur at edges E0 through E(DEPTH-1).
  - req_ready=1 and init_done=1 from after edge E(DEPTH-1).
  - The first request can be accepted at edge E(DEPTH).
- CLEAR_ON_RESET=0: req_ready=1 and init_done=1 after the first edge with rst low.
- Response latency from the accepting edge:
  - OUT_REG=0: rsp_valid is high in the following cycle, 1 edge later.
  - OUT_REG=1: rsp_valid is high 2 edges later.
- Throughput is 1 request per cycle. Back-to-back responses are consecutive, with no gap.
- Read after write to the same address on the next cycle returns the written data.

## Test plan
- Parameters DATA_WIDTH=16, DEPTH=8, CLEAR_ON_RESET=1, rst for 2 cycles:
  - req_ready stays low for exactly 8 cycles.
  - Reads of addresses 0 to 7 all return 0x0000 with rsp_err=0.
- Byte enables:
  - Write 0xABCD to address 3 with be=2'b11, then write 0x1234 with be=2'b01.
  - A read of address 3 returns 0xAB34, 1 cycle after acceptance with OUT_REG=0, or 2 cycles with OUT_REG=1.
- Read-during-write: address 5 holds 0x00FF; write 0x1100 with be=2'b11.
  - RDW_MODE=0: no rsp_valid.
  - RDW_MODE=1: returns 0x00FF.
  - RDW_MODE=2: returns 0x1100.
- DEPTH=6:
  - Write 0xBEEF to address 6: memory is unchanged.
  - A read of address 6 returns rsp_rdata=0 with rsp_err=1.
  - A read of address 5 is unaffected.
- Streaming: 8 back-to-back reads with valid held high.
  - rsp_valid is high for 8 consecutive cycles.
  - Data is returned in address order.
- Reset timing:
  - rst asserted at the 4th clear cycle: clearing restarts and req_ready rises 8 cycles after rst deasserts.
  - rst asserted with a read in flight: no rsp_valid is produced.
